// File: rtl/aes128_inv_key_sched_if.sv
// ============================================================================
// aes128_inv_key_sched_if : start/key request and round-key stream handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

interface aes128_inv_key_sched_if;
  logic         start;
  logic [127:0] key_in;
  logic         ready;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;

  modport master (
    output start, key_in, rk_ready,
    input  ready, rk_valid, rk_out, rk_round, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output ready, rk_valid, rk_out, rk_round, done
  );
endinterface

`default_nettype wire

// File: rtl/aes128_inv_key_sched.sv
// ============================================================================
// aes128_inv_key_sched : walks the AES-128 key schedule from round 10 to 0,
// one round key per handshake. Option macro: INV_KEY_MIXCOL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes128_inv_key_sched (
  input  wire logic               clk,
  input  wire logic               rst,
  aes128_inv_key_sched_if.slave   bus
);

  localparam int NK   = 4;
  localparam int NB   = 4;
  localparam int NR   = 10;
  localparam int RK_W = 32 * NB;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_ready;
  logic            r_valid;
  logic            r_done;
  logic [RK_W-1:0] r_key;
  logic [3:0]      r_round;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x14, x);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(x240, x14);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h0};
  endfunction

  logic [31:0]     w_cur [NK];
  logic [31:0]     w_nxt [NK];
  logic [31:0]     w_rot;
  logic [31:0]     w_sub;
  logic [RK_W-1:0] w_key_prev;

  // Word 0 is the most significant word of the round key.
  for (genvar i = 0; i < NK; i++) begin : g_word
    assign w_cur[i] = r_key[RK_W-1-32*i -: 32];
    assign w_key_prev[RK_W-1-32*i -: 32] = w_nxt[i];
  end

  for (genvar i = 1; i < NK; i++) begin : g_xor
    assign w_nxt[i] = w_cur[i] ^ w_cur[i-1];
  end

  assign w_rot = {w_nxt[NK-1][23:0], w_nxt[NK-1][31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign w_sub[8*b +: 8] = sbox(w_rot[8*b +: 8]);
  end

  assign w_nxt[0] = w_cur[0] ^ w_sub ^ rcon(r_round);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_key   <= '0;
      r_round <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_key   <= bus.key_in;
            r_round <= 4'(NR);
            r_valid <= 1'b1;
            r_ready <= 1'b0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_valid && bus.rk_ready) begin
            if (r_round != 4'd0) begin
              r_key   <= w_key_prev;
              r_round <= r_round - 4'd1;
            end else begin
              r_valid <= 1'b0;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready    = r_ready;
  assign bus.rk_valid = r_valid;
  assign bus.rk_round = r_round;
  assign bus.done     = r_done;

`ifdef INV_KEY_MIXCOL_EN
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [RK_W-1:0] w_imc;

  for (genvar c = 0; c < NB; c++) begin : g_col
    assign w_imc[RK_W-1-32*c -: 32] = inv_mix_col(r_key[RK_W-1-32*c -: 32]);
  end

  // Only the middle rounds use the equivalent-inverse-cipher form.
  assign bus.rk_out = (r_round >= 4'd1 && r_round <= 4'd9) ? w_imc : r_key;
`else
  assign bus.rk_out = r_key;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes128_inv_key_sched.sv
// ============================================================================
// tb_aes128_inv_key_sched : randomized bench against a forward-expansion model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes128_inv_key_sched;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];

  aes128_inv_key_sched_if bus ();

  aes128_inv_key_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box by brute-force inverse search plus bitwise affine transform.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] present(input logic [127:0] k, input int r);
    logic [127:0] o;
    o = k;
`ifdef INV_KEY_MIXCOL_EN
    if (r >= 1 && r <= 9) begin
      int m [4][4] = '{'{14, 11, 13, 9}, '{9, 14, 11, 13}, '{13, 9, 14, 11}, '{11, 13, 9, 14}};
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++) begin
          logic [7:0] acc = 8'h00;
          for (int j = 0; j < 4; j++)
            acc = acc ^ gm(8'(m[i][j]), k[127-32*c-8*j -: 8]);
          o[127-32*c-8*i -: 8] = acc;
        end
    end
`else
    if (r < 0) o = '0;
`endif
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_sched(input logic [127:0] k10);
    n_cmp++;
    if (bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_before_start: got %b expected 1", bus.ready);
    end
    bus.start  = 1'b1;
    bus.key_in = k10;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.key_in = rnd128();
  endtask

  // mode 0: always ready; 1: 3-cycle stall at round 5 + random; 2: ready + start spam; 3: random
  task automatic drain(input int mode, input int stop_k);
    int k = 10;
    int cyc = 0;
    int stall_left = 3;
    bit rdy;
    logic [127:0] want;
    while (k >= 0 && cyc < 300) begin
      want = present(exp_rk[k], k);
      n_cmp++;
      if (bus.rk_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL rk_valid: got %b expected 1 (round %0d)", bus.rk_valid, k);
      end
      n_cmp++;
      if (bus.rk_round !== 4'(k)) begin
        n_bad++;
        $display("FAIL rk_round: got %0d expected %0d", bus.rk_round, k);
      end
      n_cmp++;
      if (bus.rk_out !== want) begin
        n_bad++;
        $display("FAIL rk_out round %0d: got %h expected %h", k, bus.rk_out, want);
      end
      n_cmp++;
      if (bus.ready !== 1'b0 || bus.done !== 1'b0) begin
        n_bad++;
        $display("FAIL run_flags: got ready=%b done=%b expected 0/0", bus.ready, bus.done);
      end
      if (k == stop_k) return;
      case (mode)
        0: rdy = 1'b1;
        1: begin
          if (k == 5 && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
          end else begin
            rdy = ($urandom_range(0, 3) != 0);
          end
        end
        2: begin
          rdy = 1'b1;
          bus.start  = 1'b1;
          bus.key_in = rnd128();
        end
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      bus.rk_ready = rdy;
      @(posedge clk); #1;
      cyc++;
      if (rdy) k--;
    end
    bus.rk_ready = 1'b0;
    bus.start    = 1'b0;
    if (k >= 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d keys left expected 0", k + 1);
    end else begin
      n_cmp++;
      if (bus.done !== 1'b1 || bus.ready !== 1'b1 || bus.rk_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL end_flags: got done=%b ready=%b valid=%b expected 1/1/0",
                 bus.done, bus.ready, bus.rk_valid);
      end
      if (mode == 0 || mode == 2) begin
        n_cmp++;
        if (cyc != 11) begin
          n_bad++;
          $display("FAIL done_latency: got T+%0d expected T+12", cyc + 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.rk_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got ready=%b valid=%b done=%b expected 1/0/0",
               bus.ready, bus.rk_valid, bus.done);
    end
    n_cmp++;
    if (bus.rk_out !== 128'h0 || bus.rk_round !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_data: got out=%h round=%0d expected 0/0", bus.rk_out, bus.rk_round);
    end
    rst = 1'b0;
    bus.rk_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.rk_valid !== 1'b0 || bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_rk_ready: got ready=%b valid=%b done=%b expected 1/0/0",
               bus.ready, bus.rk_valid, bus.done);
    end
    bus.rk_ready = 1'b0;
  endtask

  task automatic load_fips();
    expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  endtask

  task automatic test_fips();
    load_fips();
    start_sched(exp_rk[10]);
    drain(0, -1);
    @(posedge clk); #1;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL done_pulse_width: got done=%b ready=%b expected 0/1", bus.done, bus.ready);
    end
  endtask

  task automatic test_stall();
    load_fips();
    start_sched(exp_rk[10]);
    drain(1, -1);
  endtask

  task automatic test_back_to_back();
    expand(rnd128());
    start_sched(exp_rk[10]);
    drain(2, -1);
    expand(rnd128());
    start_sched(exp_rk[10]);
    drain(0, -1);
  endtask

  task automatic test_rst_mid();
    load_fips();
    start_sched(exp_rk[10]);
    drain(0, 6);
    rst = 1'b1;
    bus.rk_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rk_ready = 1'b0;
    n_cmp++;
    if (bus.ready !== 1'b1 || bus.rk_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.rk_out !== 128'h0 || bus.rk_round !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_mid: got ready=%b valid=%b done=%b out=%h round=%0d expected 1/0/0/0/0",
               bus.ready, bus.rk_valid, bus.done, bus.rk_out, bus.rk_round);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.rk_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_done: got done=%b valid=%b expected 0/0", bus.done, bus.rk_valid);
    end
    start_sched(exp_rk[10]);
    drain(0, -1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      expand(rnd128());
      start_sched(exp_rk[10]);
      drain((n % 2 == 0) ? 0 : 3, -1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    build_sbox();
    test_reset();
    test_fips();
    test_stall();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
